button_sequencer: RTL and testbench

BUTTON_SEQUENCER -- requirements
Module: button_sequencer

---
 rtl/button_sequencer_pkg.sv | 16 +
 rtl/button_sequencer_debounce_pulse.sv | 45 ++++
 rtl/button_sequencer.sv | 97 +++++++++
 tb/tb_button_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_sequencer_pkg.sv
// Shared types for the button sequencer: FSM encoding and button lane indices.
package button_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 2;
  localparam int unsigned NUM_BTN   = 3;

endpackage

// File: rtl/button_sequencer_debounce_pulse.sv
// One pushbutton lane: 2-flop synchroniser, debounce window, rising-edge pulse.
module debounce_pulse #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // stable only follows sync2 after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= in;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // decoded from registers only, so the FSM sees it one edge after stable rises
  assign pulse = stable & ~stable_d;

endmodule

// File: rtl/button_sequencer.sv
// Pushbutton front-end sequencing multiplier launches and result scrolling.
//   state  | meaning
//   IDLE   | waiting for a start press
//   LAUNCH | single-cycle mult_start strobe
//   BUSY   | multiply outstanding, buttons ignored
//   DONE   | product displayed, left/right scroll, start relaunches
module button_sequencer
  import button_sequencer_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 1000000,
  parameter int unsigned SCROLL_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       mult_done,
  output logic       mult_start,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] scroll_pos
);

  localparam logic [1:0] SCROLL_TOP = 2'(SCROLL_MAX);

  logic [NUM_BTN-1:0] press;
  seq_state_t         state;
  seq_state_t         state_nx;
  logic [1:0]         scroll_q;
  logic [1:0]         scroll_nx;

  debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_start),
    .pulse (press[BTN_START])
  );

  debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_left),
    .pulse (press[BTN_LEFT])
  );

  debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_right),
    .pulse (press[BTN_RIGHT])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      scroll_q <= '0;
    end else begin
      state    <= state_nx;
      scroll_q <= scroll_nx;
    end
  end

  // start outranks left outranks right; losers in the same cycle are dropped
  always_comb begin
    state_nx  = state;
    scroll_nx = scroll_q;
    case (state)
      ST_IDLE: begin
        if (press[BTN_START]) state_nx = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        if (mult_done) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (press[BTN_START]) begin
          state_nx  = ST_LAUNCH;
          scroll_nx = '0;
        end else if (press[BTN_LEFT]) begin
          if (scroll_q < SCROLL_TOP) scroll_nx = scroll_q + 2'd1;
        end else if (press[BTN_RIGHT]) begin
          if (scroll_q != 2'd0) scroll_nx = scroll_q - 2'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mult_start   = (state == ST_LAUNCH);
  assign busy         = (state == ST_BUSY);
  assign result_valid = (state == ST_DONE);
  assign scroll_pos   = scroll_q;

endmodule

// File: tb/tb_button_sequencer.sv
// Randomised and directed bench for button_sequencer against a queue-based reference model.
module tb_button_sequencer;

  localparam int DB   = 4;
  localparam int SMAX = 2;

  localparam int M_IDLE   = 0;
  localparam int M_LAUNCH = 1;
  localparam int M_BUSY   = 2;
  localparam int M_DONE   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start;
  logic       btn_left;
  logic       btn_right;
  logic       mult_done;
  logic       mult_start;
  logic       busy;
  logic       result_valid;
  logic [1:0] scroll_pos;

  button_sequencer #(.DB_CYCLES(DB), .SCROLL_MAX(SMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start    (btn_start),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .mult_done    (mult_done),
    .mult_start   (mult_start),
    .busy         (busy),
    .result_valid (result_valid),
    .scroll_pos   (scroll_pos)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: raw history queue gives the 2-cycle synchroniser delay
  int         m_mode;
  int         m_scroll;
  int         m_stab [3];
  int         m_prev [3];
  int         m_run  [3];
  logic [2:0] hist [$];

  task automatic model_edge();
    logic [2:0] raw;
    logic [2:0] d;
    int         p [3];
    raw = {btn_right, btn_left, btn_start};
    if (rst) begin
      m_mode   = M_IDLE;
      m_scroll = 0;
      for (int b = 0; b < 3; b++) begin
        m_stab[b] = 0;
        m_prev[b] = 0;
        m_run[b]  = 0;
      end
      hist = '{3'b000, 3'b000};
    end else begin
      for (int b = 0; b < 3; b++) p[b] = (m_stab[b] == 1 && m_prev[b] == 0) ? 1 : 0;
      case (m_mode)
        M_IDLE:   if (p[0] == 1) m_mode = M_LAUNCH;
        M_LAUNCH: m_mode = M_BUSY;
        M_BUSY:   if (mult_done) m_mode = M_DONE;
        default: begin
          if (p[0] == 1) begin
            m_mode   = M_LAUNCH;
            m_scroll = 0;
          end else if (p[1] == 1) begin
            m_scroll = (m_scroll + 1 > SMAX) ? SMAX : m_scroll + 1;
          end else if (p[2] == 1) begin
            m_scroll = (m_scroll - 1 < 0) ? 0 : m_scroll - 1;
          end
        end
      endcase
      hist.push_back(raw);
      d = hist.pop_front();
      for (int b = 0; b < 3; b++) begin
        m_prev[b] = m_stab[b];
        if (int'(d[b]) != m_stab[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_stab[b] = int'(d[b]);
            m_run[b]  = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  endtask

  int edge_no   = 0;
  int ms_count  = 0;
  int ms_edge   = -1;
  int ms_scroll = -1;

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    edge_no++;
    if (mult_start === 1'b1) begin
      ms_count++;
      ms_edge   = edge_no;
      ms_scroll = int'(scroll_pos);
    end
    check("mult_start", int'(mult_start), (m_mode == M_LAUNCH) ? 1 : 0);
    check("busy", int'(busy), (m_mode == M_BUSY) ? 1 : 0);
    check("result_valid", int'(result_valid), (m_mode == M_DONE) ? 1 : 0);
    check("scroll_pos", int'(scroll_pos), m_scroll);
    @(negedge clk);
  endtask

  task automatic press(input int b, input int hold);
    if (b == 0) btn_start = 1'b1;
    if (b == 1) btn_left  = 1'b1;
    if (b == 2) btn_right = 1'b1;
    repeat (hold) tick();
    btn_start = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    repeat (10) tick();
  endtask

  int exp_left  [3] = '{1, 2, 2};
  int exp_right [3] = '{1, 0, 0};

  initial begin
    rst       = 1'b1;
    btn_start = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    mult_done = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_outputs", int'({mult_start, busy, result_valid, scroll_pos}), 0);

    // held start: one launch exactly DB+3 edges into the press
    edge_no  = 0;
    ms_count = 0;
    btn_start = 1'b1;
    repeat (20) tick();
    check("start_edge", ms_edge, DB + 3);
    check("start_once", ms_count, 1);
    check("busy_after_start", int'(busy), 1);
    btn_start = 1'b0;
    repeat (4) tick();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    tick();
    check("done_valid", int'(result_valid), 1);
    repeat (10) tick();

    for (int i = 0; i < 3; i++) begin
      press(1, 8);
      check("scroll_left", int'(scroll_pos), exp_left[i]);
    end
    for (int i = 0; i < 3; i++) begin
      press(2, 8);
      check("scroll_right", int'(scroll_pos), exp_right[i]);
    end

    // simultaneous left+start in DONE: start wins, scroll cleared
    press(1, 8);
    check("scroll_before_launch", int'(scroll_pos), 1);
    ms_count  = 0;
    ms_scroll = -1;
    btn_left  = 1'b1;
    btn_start = 1'b1;
    repeat (8) tick();
    btn_left  = 1'b0;
    btn_start = 1'b0;
    repeat (10) tick();
    check("launch_count", ms_count, 1);
    check("launch_scroll", ms_scroll, 0);
    check("busy_before_rst", int'(busy), 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_mult_start", int'(mult_start), 0);
    tick();
    check("post_rst_mult_start", int'(mult_start), 0);
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    tick();
    check("done_ignored_idle", int'(result_valid), 0);

    // bounce shorter than the window
    ms_count = 0;
    for (int i = 0; i < 3; i++) begin
      btn_start = 1'b1;
      repeat (2) tick();
      btn_start = 1'b0;
      repeat (2) tick();
    end
    repeat (12) tick();
    check("bounce_no_start", ms_count, 0);
    check("bounce_idle", int'(busy | result_valid), 0);

    // start pulse coinciding with mult_done in BUSY
    press(0, 8);
    check("busy_for_coincide", int'(busy), 1);
    ms_count  = 0;
    btn_start = 1'b1;
    repeat (DB + 2) tick();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    repeat (3) tick();
    btn_start = 1'b0;
    repeat (10) tick();
    check("coincide_no_launch", ms_count, 0);
    check("coincide_done", int'(result_valid), 1);

    // button held through reset
    btn_start = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    edge_no  = 0;
    ms_count = 0;
    repeat (12) tick();
    check("held_rst_edge", ms_edge, DB + 3);
    check("held_rst_once", ms_count, 1);
    btn_start = 1'b0;
    repeat (10) tick();

    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 9) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 9) == 0) btn_right = ~btn_right;
      mult_done = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
